// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels and registered write/read handshakes.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through data_out; default build registers data_out on each pop.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [FIFO_WIDTH-1:0]       data_out,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [AW-1:0] LAST_C  = AW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [FIFO_WIDTH-1:0] w_head;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == LAST_C) ? {AW{1'b0}} : ptr + AW'(1);
  endfunction

  // Acceptance is decided from the pre-edge occupancy, so a full FIFO never takes a write even when popping.
  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_wr_accept = wr_en & ~w_full;
  assign w_rd_accept = rd_en & ~w_empty;
  assign w_head      = r_mem[r_rd_ptr];

  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= AF_C);
  assign almostempty = (r_count <= AE_C);
  assign count       = r_count;
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  // Storage has no reset so it can map onto RAM; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_rd_accept) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_accept;
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = w_empty ? {FIFO_WIDTH{1'b0}} : w_head;
`else
  logic [FIFO_WIDTH-1:0] r_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= {FIFO_WIDTH{1'b0}};
    end else if (w_rd_accept) begin
      r_data_out <= w_head;
    end else begin
      r_data_out <= r_data_out;
    end
  end

  assign data_out = r_data_out;
`endif

endmodule
